prm_edge_mask_engine: RTL

Programmable, multi-channel successor to the fixed truth-table obstacle checkers used for PRM roadmap edge masking.
- Each of NUM_CH channels holds one roadmap edge's collision function as a sum-of-products table of up to TERMS_PER_CH product terms, loaded at run time.
- A shared IN_W-bit occupancy vector is accepted by handshake. All channels evaluate TERM_PAR terms per cycle.
- The resulting edge_mask vector is returned by handshake.
- A single engine therefore replaces many fixed checker instances.

---
 rtl/prm_edge_mask_if.sv | 42 ++++
 rtl/prm_edge_mask_engine.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/prm_edge_mask_if.sv
// Handshake and configuration bundle for prm_edge_mask_engine.
// The driver of stimulus and configuration uses master; the engine uses slave.
interface prm_edge_mask_if #(
    parameter int IN_W         = 15,
    parameter int NUM_CH       = 4,
    parameter int TERMS_PER_CH = 256,
    parameter int TERM_PAR     = 4
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDX_W = (TERMS_PER_CH > 1) ? $clog2(TERMS_PER_CH) : 1;
    localparam int EC_W  = $clog2(TERMS_PER_CH / TERM_PAR) + 1;

    logic              cfg_we;
    logic              cfg_clr;
    logic [CH_W-1:0]   cfg_ch;
    logic [IDX_W-1:0]  cfg_idx;
    logic [IN_W-1:0]   cfg_care;
    logic [IN_W-1:0]   cfg_val;
    logic              cfg_en;
    logic              cfg_ready;
    logic [NUM_CH-1:0] ch_en;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_vec;
    logic              out_valid;
    logic              out_ready;
    logic [NUM_CH-1:0] edge_mask;
    logic              busy;
    logic [EC_W-1:0]   eval_cycles;

    modport master (
        output cfg_we, cfg_clr, cfg_ch, cfg_idx, cfg_care, cfg_val, cfg_en,
        output ch_en, in_valid, in_vec, out_ready,
        input  cfg_ready, in_ready, out_valid, edge_mask, busy, eval_cycles
    );

    modport slave (
        input  cfg_we, cfg_clr, cfg_ch, cfg_idx, cfg_care, cfg_val, cfg_en,
        input  ch_en, in_valid, in_vec, out_ready,
        output cfg_ready, in_ready, out_valid, edge_mask, busy, eval_cycles
    );
endinterface

// File: rtl/prm_edge_mask_engine.sv
// Programmable multi-channel sum-of-products edge masker for PRM roadmaps.
// Each channel scans its term table TERM_PAR slots per cycle against one latched occupancy vector.
//
//   state  | meaning
//   S_IDLE | config writes allowed, waiting for an occupancy vector
//   S_EVAL | scanning one term group per cycle into per-channel accumulators
//   S_DONE | result presented, waiting for out_ready
module prm_edge_mask_engine #(
    parameter int IN_W         = 15,
    parameter int NUM_CH       = 4,
    parameter int TERMS_PER_CH = 256,
    parameter int TERM_PAR     = 4,
    parameter bit EARLY_EXIT   = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    prm_edge_mask_if.slave  bus
);
    localparam int NUM_GRP = TERMS_PER_CH / TERM_PAR;
    localparam int GRP_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;
    localparam int IDX_W   = (TERMS_PER_CH > 1) ? $clog2(TERMS_PER_CH) : 1;
    localparam int EC_W    = $clog2(NUM_GRP) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q;

    logic [IN_W-1:0]         care_q [NUM_CH][TERMS_PER_CH];
    logic [IN_W-1:0]         val_q  [NUM_CH][TERMS_PER_CH];
    logic [TERMS_PER_CH-1:0] tv_q   [NUM_CH];

    logic [IN_W-1:0]   vec_q;
    logic [NUM_CH-1:0] en_q;
    logic [NUM_CH-1:0] acc_q;
    logic [GRP_W-1:0]  grp_q;
    logic [GRP_W-1:0]  grp_left_q;
    logic [EC_W-1:0]   cnt_q;

    logic              out_valid_q;
    logic              in_ready_q;
    logic              cfg_ready_q;
    logic              busy_q;
    logic [NUM_CH-1:0] edge_mask_q;
    logic [EC_W-1:0]   eval_cycles_q;

    logic              cfg_ok;
    logic              ch_ok;
    logic [IDX_W-1:0]  idx;
    logic [NUM_CH-1:0] grp_hit;
    logic [NUM_CH-1:0] acc_nx;
    logic              all_done;
    logic              last_grp;
    logic              finish;

    assign cfg_ok = (state_q == S_IDLE);
    assign ch_ok  = (int'(bus.cfg_ch) < NUM_CH);

    // Term table; clear wins over a same-cycle write and only valid bits are cleared.
    always_ff @(posedge clk or negedge rst_n) begin : term_store
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                tv_q[c] <= '0;
                for (int t = 0; t < TERMS_PER_CH; t++) begin
                    care_q[c][t] <= '0;
                    val_q[c][t]  <= '0;
                end
            end
        end else if (cfg_ok) begin
            if (bus.cfg_clr) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    tv_q[c] <= '0;
                end
            end else if (bus.cfg_we && ch_ok) begin
                care_q[bus.cfg_ch][bus.cfg_idx] <= bus.cfg_care;
                val_q[bus.cfg_ch][bus.cfg_idx]  <= bus.cfg_val;
                tv_q[bus.cfg_ch][bus.cfg_idx]   <= bus.cfg_en;
            end
        end
    end

    always_comb begin
        idx     = '0;
        grp_hit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int j = 0; j < TERM_PAR; j++) begin
                idx = IDX_W'(int'(grp_q) * TERM_PAR + j);
                if (tv_q[c][idx] &&
                    (((vec_q ^ val_q[c][idx]) & care_q[c][idx]) == '0)) begin
                    grp_hit[c] = 1'b1;
                end
            end
        end
    end

    // Disabled channels count as already resolved so an all-disabled request exits after one group.
    assign acc_nx   = acc_q | grp_hit;
    assign all_done = &(acc_nx | ~en_q);
    assign last_grp = (grp_left_q == '0);
    assign finish   = last_grp || (EARLY_EXIT && all_done);

    always_ff @(posedge clk or negedge rst_n) begin : fsm
        if (!rst_n) begin
            state_q       <= S_IDLE;
            vec_q         <= '0;
            en_q          <= '0;
            acc_q         <= '0;
            grp_q         <= '0;
            grp_left_q    <= '0;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b1;
            cfg_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            edge_mask_q   <= '0;
            eval_cycles_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        vec_q       <= bus.in_vec;
                        en_q        <= bus.ch_en;
                        acc_q       <= '0;
                        grp_q       <= '0;
                        grp_left_q  <= GRP_W'(NUM_GRP - 1);
                        cnt_q       <= '0;
                        in_ready_q  <= 1'b0;
                        cfg_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    acc_q      <= acc_nx;
                    grp_q      <= grp_q + GRP_W'(1);
                    grp_left_q <= grp_left_q - GRP_W'(1);
                    cnt_q      <= cnt_q + EC_W'(1);
                    if (finish) begin
                        edge_mask_q   <= acc_nx & en_q;
                        eval_cycles_q <= cnt_q + EC_W'(1);
                        out_valid_q   <= 1'b1;
                        state_q       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        cfg_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    cfg_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.in_ready    = in_ready_q;
    assign bus.cfg_ready   = cfg_ready_q;
    assign bus.busy        = busy_q;
    assign bus.edge_mask   = edge_mask_q;
    assign bus.eval_cycles = eval_cycles_q;
endmodule
